tl_addr_router: RTL and testbench

Parametrised TileLink-UL A/D router between one master port and N slave ports. It decodes each A-channel address against N base/size regions, forwards the beat to the matching slave, and returns D responses to the master in request order. Unmapped addresses go to an internal error responder, which answers with `d_denied`. It sits at the bus fabric boundary and replaces fixed two-region one-hot decoding with a configurable, flow-controlled router.

---
 rtl/tl_addr_router.sv | 206 ++++++++++++++++++++
 tb/tb_tl_addr_router.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_addr_router.sv
// TileLink-UL A/D router: decodes A-channel addresses onto N slave regions plus an
// internal error responder, and returns D beats in request order.
module tl_addr_router #(
    parameter int N_SLAVES = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int SRC_W    = 4,
    parameter int MAX_OUT  = 4,
    parameter logic [N_SLAVES*ADDR_W-1:0] REGION_BASE = {32'h2000, 32'h0000},
    parameter logic [N_SLAVES*ADDR_W-1:0] REGION_SIZE = {32'h2000, 32'h2000}
) (
    input  logic                           clock,
    input  logic                           reset,
    // master A
    input  logic                           a_valid,
    output logic                           a_ready,
    input  logic [2:0]                     a_opcode,
    input  logic [2:0]                     a_size,
    input  logic [SRC_W-1:0]               a_source,
    input  logic [ADDR_W-1:0]              a_address,
    input  logic [DATA_W/8-1:0]            a_mask,
    input  logic [DATA_W-1:0]              a_data,
    // master D
    output logic                           d_valid,
    input  logic                           d_ready,
    output logic [2:0]                     d_opcode,
    output logic [2:0]                     d_size,
    output logic [SRC_W-1:0]               d_source,
    output logic [DATA_W-1:0]              d_data,
    output logic                           d_denied,
    // slave A
    output logic [N_SLAVES-1:0]            s_a_valid,
    input  logic [N_SLAVES-1:0]            s_a_ready,
    output logic [2:0]                     s_a_opcode,
    output logic [2:0]                     s_a_size,
    output logic [SRC_W-1:0]               s_a_source,
    output logic [ADDR_W-1:0]              s_a_address,
    output logic [DATA_W/8-1:0]            s_a_mask,
    output logic [DATA_W-1:0]              s_a_data,
    // slave D
    input  logic [N_SLAVES-1:0]            s_d_valid,
    output logic [N_SLAVES-1:0]            s_d_ready,
    input  logic [N_SLAVES*3-1:0]          s_d_opcode,
    input  logic [N_SLAVES*3-1:0]          s_d_size,
    input  logic [N_SLAVES*SRC_W-1:0]      s_d_source,
    input  logic [N_SLAVES*DATA_W-1:0]     s_d_data,
    input  logic [N_SLAVES-1:0]            s_d_denied,
    // status
    output logic [N_SLAVES:0]              route_oh,
    output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
    output logic                           err_hit
);

    localparam int TGT_W = $clog2(N_SLAVES + 1);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(N_SLAVES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TGT_W-1:0] cur_tgt_q, cur_tgt_d;
    logic             err_full_q, err_full_d;
    logic [2:0]       err_opcode_q, err_opcode_d;
    logic [2:0]       err_size_q, err_size_d;
    logic [SRC_W-1:0] err_source_q, err_source_d;
    logic             err_hit_q, err_hit_d;

    logic [N_SLAVES-1:0] hit;
    logic [TGT_W-1:0]    tgt;
    logic                stall;
    logic                a_fire;
    logic                d_fire;
    logic                err_fire;

    // Per-region decode; the subtraction only matters once address >= base, so it never wraps.
    generate
        for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_dec
            logic [ADDR_W-1:0] base;
            logic [ADDR_W-1:0] size;
            assign base    = REGION_BASE[gi*ADDR_W +: ADDR_W];
            assign size    = REGION_SIZE[gi*ADDR_W +: ADDR_W];
            assign hit[gi] = (a_address >= base) && ((a_address - base) < size);
        end
    endgenerate

    always_comb begin
        tgt = ERR_TGT;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                tgt = TGT_W'(i);
            end
        end
        route_oh      = '0;
        route_oh[tgt] = 1'b1;
    end

    // Holding new requests while a different target has responses pending keeps D in order.
    always_comb begin
        stall     = (cnt_q == CNT_MAX) || ((cnt_q != '0) && (tgt != cur_tgt_q));
        a_ready   = 1'b0;
        s_a_valid = '0;
        if (!stall) begin
            if (tgt == ERR_TGT) begin
                a_ready = !err_full_q;
            end else begin
                for (int i = 0; i < N_SLAVES; i++) begin
                    if (tgt == TGT_W'(i)) begin
                        a_ready      = s_a_ready[i];
                        s_a_valid[i] = a_valid;
                    end
                end
            end
        end
    end

    assign s_a_opcode  = a_opcode;
    assign s_a_size    = a_size;
    assign s_a_source  = a_source;
    assign s_a_address = a_address;
    assign s_a_mask    = a_mask;
    assign s_a_data    = a_data;

    always_comb begin
        d_valid   = 1'b0;
        d_opcode  = 3'd0;
        d_size    = 3'd0;
        d_source  = '0;
        d_data    = '0;
        d_denied  = 1'b0;
        s_d_ready = '0;
        if (cnt_q != '0) begin
            if (cur_tgt_q == ERR_TGT) begin
                d_valid  = err_full_q;
                d_opcode = (err_opcode_q == 3'd4) ? 3'd1 : 3'd0;
                d_size   = err_size_q;
                d_source = err_source_q;
                d_denied = 1'b1;
            end else begin
                for (int i = 0; i < N_SLAVES; i++) begin
                    if (cur_tgt_q == TGT_W'(i)) begin
                        d_valid      = s_d_valid[i];
                        d_opcode     = s_d_opcode[i*3 +: 3];
                        d_size       = s_d_size[i*3 +: 3];
                        d_source     = s_d_source[i*SRC_W +: SRC_W];
                        d_data       = s_d_data[i*DATA_W +: DATA_W];
                        d_denied     = s_d_denied[i];
                        s_d_ready[i] = d_ready;
                    end
                end
            end
        end
    end

    always_comb begin
        a_fire   = a_valid && a_ready;
        d_fire   = d_valid && d_ready;
        err_fire = a_fire && (tgt == ERR_TGT);

        cnt_d = cnt_q;
        if (a_fire && !d_fire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!a_fire && d_fire) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        cur_tgt_d = a_fire ? tgt : cur_tgt_q;

        err_full_d   = err_full_q;
        err_opcode_d = err_opcode_q;
        err_size_d   = err_size_q;
        err_source_d = err_source_q;
        if (err_fire) begin
            err_full_d   = 1'b1;
            err_opcode_d = a_opcode;
            err_size_d   = a_size;
            err_source_d = a_source;
        end else if (d_fire && (cur_tgt_q == ERR_TGT)) begin
            err_full_d = 1'b0;
        end

        err_hit_d = err_fire;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            cur_tgt_q    <= '0;
            err_full_q   <= 1'b0;
            err_opcode_q <= 3'd0;
            err_size_q   <= 3'd0;
            err_source_q <= '0;
            err_hit_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            cur_tgt_q    <= cur_tgt_d;
            err_full_q   <= err_full_d;
            err_opcode_q <= err_opcode_d;
            err_size_q   <= err_size_d;
            err_source_q <= err_source_d;
            err_hit_q    <= err_hit_d;
        end
    end

    assign outstanding = cnt_q;
    assign err_hit     = err_hit_q;

endmodule

// File: tb/tb_tl_addr_router.sv
// Directed bench for tl_addr_router with default parameters (two 8 KiB regions at 0x0 and 0x2000).
module tb_tl_addr_router;

    localparam int N      = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SRC_W  = 4;

    logic                     clock;
    logic                     reset;
    logic                     a_valid;
    logic                     a_ready;
    logic [2:0]               a_opcode;
    logic [2:0]               a_size;
    logic [SRC_W-1:0]         a_source;
    logic [ADDR_W-1:0]        a_address;
    logic [DATA_W/8-1:0]      a_mask;
    logic [DATA_W-1:0]        a_data;
    logic                     d_valid;
    logic                     d_ready;
    logic [2:0]               d_opcode;
    logic [2:0]               d_size;
    logic [SRC_W-1:0]         d_source;
    logic [DATA_W-1:0]        d_data;
    logic                     d_denied;
    logic [N-1:0]             s_a_valid;
    logic [N-1:0]             s_a_ready;
    logic [2:0]               s_a_opcode;
    logic [2:0]               s_a_size;
    logic [SRC_W-1:0]         s_a_source;
    logic [ADDR_W-1:0]        s_a_address;
    logic [DATA_W/8-1:0]      s_a_mask;
    logic [DATA_W-1:0]        s_a_data;
    logic [N-1:0]             s_d_valid;
    logic [N-1:0]             s_d_ready;
    logic [N*3-1:0]           s_d_opcode;
    logic [N*3-1:0]           s_d_size;
    logic [N*SRC_W-1:0]       s_d_source;
    logic [N*DATA_W-1:0]      s_d_data;
    logic [N-1:0]             s_d_denied;
    logic [N:0]               route_oh;
    logic [2:0]               outstanding;
    logic                     err_hit;

    int n_checks;
    int n_errors;

    tl_addr_router dut (
        .clock(clock), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source), .d_data(d_data), .d_denied(d_denied),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_size(s_a_size), .s_a_source(s_a_source), .s_a_address(s_a_address),
        .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_size(s_d_size), .s_d_source(s_d_source), .s_d_data(s_d_data),
        .s_d_denied(s_d_denied),
        .route_oh(route_oh), .outstanding(outstanding), .err_hit(err_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [2:0] op, input logic [SRC_W-1:0] src,
                           input logic [ADDR_W-1:0] addr);
        a_valid   = v;
        a_opcode  = op;
        a_size    = 3'd2;
        a_source  = src;
        a_address = addr;
    endtask

    task automatic slave_d(input int idx, input logic v, input logic [2:0] op,
                           input logic [SRC_W-1:0] src, input logic [DATA_W-1:0] data);
        s_d_valid                        = '0;
        s_d_valid[idx]                   = v;
        s_d_opcode[idx*3 +: 3]           = op;
        s_d_size[idx*3 +: 3]             = 3'd2;
        s_d_source[idx*SRC_W +: SRC_W]   = src;
        s_d_data[idx*DATA_W +: DATA_W]   = data;
        s_d_denied[idx]                  = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b0;
        a_valid    = 1'b0;
        a_opcode   = 3'd0;
        a_size     = 3'd0;
        a_source   = '0;
        a_address  = '0;
        a_mask     = 4'hF;
        a_data     = 32'h0;
        d_ready    = 1'b0;
        s_a_ready  = 2'b11;
        s_d_valid  = '0;
        s_d_opcode = '0;
        s_d_size   = '0;
        s_d_source = '0;
        s_d_data   = '0;
        s_d_denied = '0;

        // Reset state
        step();
        step();
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_d_valid", 64'(d_valid), 64'd0);
        check("rst_s_a_valid", 64'(s_a_valid), 64'd0);
        check("rst_s_d_ready", 64'(s_d_ready), 64'd0);
        check("rst_err_hit", 64'(err_hit), 64'd0);
        reset = 1'b1;

        // Region 0 read, slave answers three cycles later
        step();
        drive_a(1'b1, 3'd4, 4'd5, 32'h0000_0100);
        #1;
        check("r0_route_oh", 64'(route_oh), 64'b001);
        check("r0_a_ready", 64'(a_ready), 64'd1);
        check("r0_s_a_valid", 64'(s_a_valid), 64'b01);
        check("r0_s_a_source", 64'(s_a_source), 64'd5);
        step();
        a_valid = 1'b0;
        check("r0_outstanding_1", 64'(outstanding), 64'd1);
        step();
        step();
        step();
        slave_d(0, 1'b1, 3'd1, 4'd5, 32'hDEAD_BEEF);
        d_ready = 1'b1;
        #1;
        check("r0_d_valid", 64'(d_valid), 64'd1);
        check("r0_d_opcode", 64'(d_opcode), 64'd1);
        check("r0_d_data", 64'(d_data), 64'hDEAD_BEEF);
        check("r0_d_source", 64'(d_source), 64'd5);
        check("r0_d_denied", 64'(d_denied), 64'd0);
        check("r0_s_d_ready", 64'(s_d_ready), 64'b01);
        step();
        s_d_valid = '0;
        #1;
        check("r0_outstanding_0", 64'(outstanding), 64'd0);
        check("r0_d_valid_idle", 64'(d_valid), 64'd0);

        // Region boundaries and error responder
        drive_a(1'b0, 3'd4, 4'd9, 32'h0000_1FFF);
        #1;
        check("bnd_1fff", 64'(route_oh), 64'b001);
        a_address = 32'h0000_2000;
        #1;
        check("bnd_2000", 64'(route_oh), 64'b010);
        a_address = 32'h0000_3FFF;
        #1;
        check("bnd_3fff", 64'(route_oh), 64'b010);
        drive_a(1'b1, 3'd4, 4'd9, 32'h0000_4000);
        #1;
        check("bnd_4000", 64'(route_oh), 64'b100);
        check("err_a_ready", 64'(a_ready), 64'd1);
        check("err_s_a_valid", 64'(s_a_valid), 64'b00);
        step();
        a_valid = 1'b0;
        #1;
        check("err_hit_pulse", 64'(err_hit), 64'd1);
        check("err_d_valid", 64'(d_valid), 64'd1);
        check("err_d_opcode", 64'(d_opcode), 64'd1);
        check("err_d_denied", 64'(d_denied), 64'd1);
        check("err_d_data", 64'(d_data), 64'd0);
        check("err_d_source", 64'(d_source), 64'd9);
        check("err_d_size", 64'(d_size), 64'd2);
        step();
        check("err_hit_clear", 64'(err_hit), 64'd0);
        check("err_d_done", 64'(d_valid), 64'd0);
        check("err_outstanding", 64'(outstanding), 64'd0);

        // Target-switch stall
        drive_a(1'b1, 3'd4, 4'd1, 32'h0000_0100);
        step();
        a_source = 4'd2;
        step();
        drive_a(1'b1, 3'd4, 4'd3, 32'h0000_2000);
        #1;
        check("sw_a_ready_0", 64'(a_ready), 64'd0);
        check("sw_s_a_valid", 64'(s_a_valid), 64'b00);
        check("sw_outstanding_2", 64'(outstanding), 64'd2);
        step();
        slave_d(0, 1'b1, 3'd1, 4'd1, 32'h1);
        #1;
        check("sw_a_ready_1", 64'(a_ready), 64'd0);
        step();
        slave_d(0, 1'b1, 3'd1, 4'd2, 32'h2);
        #1;
        check("sw_outstanding_1", 64'(outstanding), 64'd1);
        check("sw_d_source", 64'(d_source), 64'd2);
        check("sw_a_ready_2", 64'(a_ready), 64'd0);
        step();
        s_d_valid = '0;
        #1;
        check("sw_a_ready_free", 64'(a_ready), 64'd1);
        check("sw_s_a_valid_1", 64'(s_a_valid), 64'b10);
        step();
        a_valid = 1'b0;
        slave_d(1, 1'b1, 3'd1, 4'd3, 32'h11);
        #1;
        check("sw_outstanding_s1", 64'(outstanding), 64'd1);
        check("sw_d_data_s1", 64'(d_data), 64'h11);
        check("sw_s_d_ready", 64'(s_d_ready), 64'b10);
        step();
        s_d_valid = '0;

        // Outstanding limit with Puts to slave 1
        d_ready = 1'b0;
        drive_a(1'b1, 3'd0, 4'd6, 32'h0000_2004);
        for (int i = 0; i < 4; i++) step();
        check("lim_outstanding_4", 64'(outstanding), 64'd4);
        check("lim_a_ready_full", 64'(a_ready), 64'd0);
        step();
        check("lim_hold", 64'(outstanding), 64'd4);
        slave_d(1, 1'b1, 3'd0, 4'd6, 32'h0);
        d_ready = 1'b1;
        #1;
        check("lim_a_ready_dfire", 64'(a_ready), 64'd0);
        step();
        check("lim_outstanding_3", 64'(outstanding), 64'd3);
        check("lim_a_ready_open", 64'(a_ready), 64'd1);
        step();
        check("lim_simul", 64'(outstanding), 64'd3);
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        s_d_valid = '0;
        #1;
        check("lim_drained", 64'(outstanding), 64'd0);

        // Backpressure on the error response
        d_ready = 1'b0;
        drive_a(1'b1, 3'd0, 4'd7, 32'h0000_4000);
        a_size = 3'd1;
        step();
        drive_a(1'b1, 3'd4, 4'd8, 32'h0000_5000);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_d_valid", 64'(d_valid), 64'd1);
            check("bp_d_opcode", 64'(d_opcode), 64'd0);
            check("bp_d_source", 64'(d_source), 64'd7);
            check("bp_d_size", 64'(d_size), 64'd1);
            check("bp_a_ready", 64'(a_ready), 64'd0);
            step();
        end
        d_ready = 1'b1;
        #1;
        check("bp_a_ready_rise", 64'(a_ready), 64'd0);
        step();
        check("bp_a_ready_next", 64'(a_ready), 64'd1);
        step();
        a_valid = 1'b0;
        #1;
        check("bp_new_d_opcode", 64'(d_opcode), 64'd1);
        check("bp_new_d_source", 64'(d_source), 64'd8);
        step();
        check("bp_outstanding", 64'(outstanding), 64'd0);

        // Reset in the middle of three pending reads
        d_ready = 1'b0;
        drive_a(1'b1, 3'd4, 4'd2, 32'h0000_0010);
        for (int i = 0; i < 3; i++) step();
        a_valid = 1'b0;
        slave_d(0, 1'b1, 3'd1, 4'd2, 32'h55);
        #1;
        check("mr_outstanding_3", 64'(outstanding), 64'd3);
        check("mr_d_valid_pre", 64'(d_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("mr_outstanding_0", 64'(outstanding), 64'd0);
        check("mr_d_valid", 64'(d_valid), 64'd0);
        check("mr_s_a_valid", 64'(s_a_valid), 64'd0);
        s_d_valid = '0;
        step();
        reset = 1'b1;
        step();
        drive_a(1'b1, 3'd4, 4'd4, 32'h0000_0020);
        #1;
        check("mr_a_ready", 64'(a_ready), 64'd1);
        step();
        a_valid = 1'b0;
        slave_d(0, 1'b1, 3'd1, 4'd4, 32'hCAFE_0001);
        d_ready = 1'b1;
        #1;
        check("mr_d_data", 64'(d_data), 64'hCAFE_0001);
        check("mr_d_source", 64'(d_source), 64'd4);
        step();
        s_d_valid = '0;
        #1;
        check("mr_done", 64'(outstanding), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
